// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the genericfir stream controller.
package fir_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_e;

  function automatic int ow_calc(input int iw);
    return 2 * iw + 7;
  endfunction
endpackage

// File: rtl/fir_stream_ctrl_if.sv
// Handshake/bus bundle between the stream controller and its environment
// (sample source, result sink, tap writer and the genericfir core).
interface fir_stream_ctrl_if
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int IW    = 12,
  parameter int OW    = ow_calc(IW),
  parameter int LENW  = 16
);
  localparam int IDXW = $clog2(NTAPS + 1);

  logic                     i_start;
  logic [LENW-1:0]          i_length;
  logic                     o_busy;
  logic                     o_done;
  logic                     i_tap_valid;
  logic [IDXW-1:0]          i_tap_idx;
  logic [IW-1:0]            i_tap_data;
  logic                     o_tap_ready;
  logic                     i_s_valid;
  logic [IW-1:0]            i_s_data;
  logic                     o_s_ready;
  logic                     o_fir_ce;
  logic [IW-1:0]            o_fir_sample;
  logic                     o_fir_tap_wr;
  logic [(NTAPS+1)*IW-1:0]  o_fir_taps;
  logic [LENW-1:0]          o_fir_out_len;
  logic [OW-1:0]            i_fir_result;
  logic                     i_fir_valid;
  logic                     i_fir_clean_pip;
  logic                     o_r_valid;
  logic [OW-1:0]            o_r_data;
  logic                     o_r_last;
  logic                     i_r_ready;

  modport master (
    input  i_start, i_length, i_tap_valid, i_tap_idx, i_tap_data, i_s_valid, i_s_data,
           i_fir_result, i_fir_valid, i_fir_clean_pip, i_r_ready,
    output o_busy, o_done, o_tap_ready, o_s_ready, o_fir_ce, o_fir_sample, o_fir_tap_wr,
           o_fir_taps, o_fir_out_len, o_r_valid, o_r_data, o_r_last
  );

  modport slave (
    output i_start, i_length, i_tap_valid, i_tap_idx, i_tap_data, i_s_valid, i_s_data,
           i_fir_result, i_fir_valid, i_fir_clean_pip, i_r_ready,
    input  o_busy, o_done, o_tap_ready, o_s_ready, o_fir_ce, o_fir_sample, o_fir_tap_wr,
           o_fir_taps, o_fir_out_len, o_r_valid, o_r_data, o_r_last
  );
endinterface

// File: rtl/fir_result_fifo.sv
// Small synchronous FIFO holding {last, result}; read data is the head entry, stable until popped.
module fir_result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         one
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr, rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign one   = (cnt == (AW+1)'(1));
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/fir_stream_ctrl.sv
// Feeds a burst of samples into genericfir, flushes it with zeros and
// returns exactly `length` results through a small result FIFO.
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS  = 8,
  parameter int IW     = 12,
  parameter int OW     = ow_calc(IW),
  parameter int LENW   = 16,
  parameter int RDEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  fir_stream_ctrl_if.master bus
);
  state_e                 state, state_nxt;
  logic [LENW-1:0]        len_q, scnt, rcnt;
  logic [NTAPS:0][IW-1:0] taps;
  logic                   tap_wr_q, done_q, done_nxt, alive_q;
  logic                   ce, s_acc, push, pop, tap_we;
  logic [IW-1:0]          smp;
  logic                   f_full, f_empty, f_one;
  logic [OW:0]            f_rdata;

  // alive_q keeps tap_ready low while reset is held, so every output reads 0 in reset
  assign bus.o_tap_ready   = alive_q & (state == IDLE);
  assign bus.o_busy        = (state != IDLE);
  assign bus.o_done        = done_q;
  assign bus.o_s_ready     = s_acc;
  assign bus.o_fir_ce      = ce;
  assign bus.o_fir_sample  = smp;
  assign bus.o_fir_tap_wr  = tap_wr_q;
  assign bus.o_fir_taps    = taps;
  assign bus.o_fir_out_len = len_q;
  assign bus.o_r_valid     = ~f_empty;
  assign bus.o_r_data      = f_empty ? '0 : f_rdata[OW-1:0];
  assign bus.o_r_last      = ~f_empty & f_rdata[OW];

  assign tap_we = bus.o_tap_ready & bus.i_tap_valid & (32'(bus.i_tap_idx) <= NTAPS);
  assign push   = bus.i_fir_valid & ce & (rcnt < len_q);
  assign pop    = ~f_empty & bus.i_r_ready;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ce        = 1'b0;
    s_acc     = 1'b0;
    smp       = '0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_length == '0) done_nxt = 1'b1;
          else                    state_nxt = STREAM;
        end
      end
      STREAM: begin
        s_acc = bus.i_s_valid & ~f_full;
        ce    = s_acc;
        smp   = bus.i_s_data;
        if (s_acc && scnt == len_q - 1'b1) state_nxt = FLUSH;
      end
      FLUSH: begin
        ce = bus.i_fir_clean_pip & ~f_full;
        // leave as soon as the final result is being captured this cycle
        if (rcnt == len_q || (ce && bus.i_fir_valid && rcnt == len_q - 1'b1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (f_empty || (pop && f_one)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      len_q    <= '0;
      scnt     <= '0;
      rcnt     <= '0;
      taps     <= '0;
      tap_wr_q <= 1'b0;
      done_q   <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_q   <= done_nxt;
      alive_q  <= 1'b1;
      tap_wr_q <= (state == IDLE) & bus.i_start & (bus.i_length != '0);
      if (tap_we) taps[bus.i_tap_idx] <= bus.i_tap_data;
      if (state == IDLE && bus.i_start) begin
        len_q <= bus.i_length;
        scnt  <= '0;
        rcnt  <= '0;
      end else begin
        if (s_acc) scnt <= scnt + 1'b1;
        if (push)  rcnt <= rcnt + 1'b1;
      end
    end
  end

  fir_result_fifo #(.W(OW + 1), .DEPTH(RDEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (push),
    .wdata ({rcnt == len_q - 1'b1, bus.i_fir_result}),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .one   (f_one)
  );
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: a behavioural FIR stands in for genericfir,
// impulse bursts are checked against a vector table, corner cases by hand.
module tb_fir_stream_ctrl;
  localparam int NTAPS = 8, IW = 12, OW = 2 * IW + 7, LENW = 16, RDEPTH = 4, NS = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_stream_ctrl_if #(.NTAPS(NTAPS), .IW(IW), .OW(OW), .LENW(LENW)) bus ();
  fir_stream_ctrl #(.NTAPS(NTAPS), .IW(IW), .OW(OW), .LENW(LENW), .RDEPTH(RDEPTH)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  // ---------------- golden FIR: one result per ce, one-cycle latency ----------------
  function automatic logic signed [OW-1:0] sx(input logic [IW-1:0] v);
    return {{(OW-IW){v[IW-1]}}, v};
  endfunction

  logic signed [OW-1:0] m_taps [NTAPS+1];
  logic signed [OW-1:0] eff_tap [NTAPS+1];
  logic signed [OW-1:0] m_dl [NTAPS];
  logic signed [OW-1:0] m_res, m_nxt;
  logic                 m_valid;

  always_comb begin
    eff_tap = '{default: '0};
    m_nxt   = '0;
    for (int k = 0; k <= NTAPS; k++)
      eff_tap[k] = bus.o_fir_tap_wr ? sx(bus.o_fir_taps[k*IW +: IW]) : m_taps[k];
    m_nxt = sx(bus.o_fir_sample) * eff_tap[0];
    for (int k = 1; k <= NTAPS; k++) m_nxt = m_nxt + m_dl[k-1] * eff_tap[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_res   <= '0;
      for (int k = 0; k <= NTAPS; k++) m_taps[k] <= '0;
      for (int k = 0; k < NTAPS; k++)  m_dl[k]   <= '0;
    end else begin
      if (bus.o_fir_tap_wr) for (int k = 0; k <= NTAPS; k++) m_taps[k] <= eff_tap[k];
      if (!bus.o_busy) begin
        m_valid <= 1'b0;
        for (int k = 0; k < NTAPS; k++) m_dl[k] <= '0;
      end else if (bus.o_fir_ce) begin
        m_res   <= m_nxt;
        m_valid <= 1'b1;
        m_dl[0] <= sx(bus.o_fir_sample);
        for (int k = 1; k < NTAPS; k++) m_dl[k] <= m_dl[k-1];
      end
    end
  end

  assign bus.i_fir_result    = m_res;
  assign bus.i_fir_valid     = m_valid;
  assign bus.i_fir_clean_pip = 1'b1;

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [OW:0] rq[$];
  int ce_cnt = 0, tw_cnt = 0, busy_cnt = 0, done_cnt = 0;
  int last_pop_cyc = 0, last_done_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_r_valid && bus.i_r_ready) begin
        rq.push_back({bus.o_r_last, bus.o_r_data});
        last_pop_cyc <= cyc;
      end
      if (bus.o_fir_ce)     ce_cnt   <= ce_cnt + 1;
      if (bus.o_fir_tap_wr) tw_cnt   <= tw_cnt + 1;
      if (bus.o_busy)       busy_cnt <= busy_cnt + 1;
      if (bus.o_done) begin
        done_cnt      <= done_cnt + 1;
        last_done_cyc <= cyc;
      end
    end
  end

  // ---------------- checking helpers ----------------
  typedef struct {
    logic [IW-1:0] s;
    logic [OW-1:0] res;
    logic          last;
  } vec_t;
  vec_t vec [NS];

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_taps();
    for (int k = 0; k <= NTAPS; k++) begin
      bus.i_tap_valid = 1'b1;
      bus.i_tap_idx   = 4'(k);
      bus.i_tap_data  = 12'(8 + k);
      tick();
    end
    bus.i_tap_valid = 1'b0;
  endtask

  task automatic start(input int len);
    bus.i_start  = 1'b1;
    bus.i_length = 16'(len);
    tick();
    bus.i_start  = 1'b0;
  endtask

  // gap idle cycles, then hold valid until accepted; optionally check ce tracks valid
  task automatic send(input logic [IW-1:0] d, input int gap, input bit chk_ce);
    logic acc;
    int   n;
    for (int g = 0; g < gap; g++) begin
      bus.i_s_valid = 1'b0;
      @(negedge clk);
      if (chk_ce) chk("gap_ce", bus.o_fir_ce, 1'b0);
      @(posedge clk); #1;
    end
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = d;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.o_s_ready;
      if (chk_ce && n == 0) chk("valid_ce", bus.o_fir_ce, 1'b1);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
  endtask

  task automatic wait_done(input string name);
    logic seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = bus.o_done;
    end
    chk(name, seen, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_res(input string name, input int base);
    chk({name, "_count"}, rq.size() - base, NS);
    for (int i = 0; i < NS; i++) begin
      if (base + i < rq.size()) begin
        chk($sformatf("%s_res%0d", name, i), rq[base+i][OW-1:0], vec[i].res);
        chk($sformatf("%s_last%0d", name, i), rq[base+i][OW], vec[i].last);
      end
    end
  endtask

  task automatic impulse_burst(input string name, input bit gaps);
    int base = rq.size();
    start(NS);
    for (int i = 0; i < NS; i++) send(vec[i].s, gaps ? i % 2 : 0, gaps);
    wait_done({name, "_done"});
    check_res(name, base);
    chk({name, "_done_after_pop"}, last_done_cyc - last_pop_cyc, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, c0, t0, b0, d0;
    logic [(NTAPS+1)*IW-1:0] exp_taps;

    for (int i = 0; i < NS; i++) begin
      vec[i].s    = (i == 0) ? 12'd1 : 12'd0;
      vec[i].res  = OW'(8 + i);
      vec[i].last = (i == NS - 1);
    end
    for (int k = 0; k <= NTAPS; k++) exp_taps[k*IW +: IW] = 12'(8 + k);

    bus.i_start = 1'b0; bus.i_length = '0; bus.i_tap_valid = 1'b0; bus.i_tap_idx = '0;
    bus.i_tap_data = '0; bus.i_s_valid = 1'b0; bus.i_s_data = '0; bus.i_r_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_tap_ready", bus.o_tap_ready, 1'b0);
    chk("rst_r_valid", bus.o_r_valid, 1'b0);
    chk("rst_taps", bus.o_fir_taps, '0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_tap_ready", bus.o_tap_ready, 1'b1);
    write_taps();
    chk("taps_written", bus.o_fir_taps, exp_taps);

    // 1. impulse, with tap_wr pulse and latched length right after start
    base = rq.size();
    start(NS);
    chk("start_tap_wr", bus.o_fir_tap_wr, 1'b1);
    chk("start_busy", bus.o_busy, 1'b1);
    chk("start_out_len", bus.o_fir_out_len, NS);
    for (int i = 0; i < NS; i++) send(vec[i].s, 0, 1'b0);
    wait_done("imp_done");
    check_res("imp", base);
    chk("imp_done_after_pop", last_done_cyc - last_pop_cyc, 1);

    // 2. backpressure: sink stalled until the FIFO fills
    bus.i_r_ready = 1'b0;
    base = rq.size();
    start(NS);
    for (int i = 0; i < 5; i++) send(vec[i].s, 0, 1'b0);
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = vec[5].s;
    tick(); tick();
    @(negedge clk);
    chk("bp_ce", bus.o_fir_ce, 1'b0);
    chk("bp_s_ready", bus.o_s_ready, 1'b0);
    chk("bp_r_valid", bus.o_r_valid, 1'b1);
    chk("bp_head", bus.o_r_data, OW'(8));
    @(negedge clk);
    chk("bp_head_hold", bus.o_r_data, OW'(8));
    @(posedge clk); #1;
    bus.i_r_ready = 1'b1;
    for (int i = 5; i < NS; i++) send(vec[i].s, 0, 1'b0);
    wait_done("bp_done");
    check_res("bp", base);

    // 3. zero length
    c0 = ce_cnt; t0 = tw_cnt; b0 = busy_cnt; d0 = done_cnt;
    start(0);
    chk("zl_done", bus.o_done, 1'b1);
    chk("zl_busy", bus.o_busy, 1'b0);
    tick(); tick(); tick();
    chk("zl_ce_cnt", ce_cnt - c0, 0);
    chk("zl_tw_cnt", tw_cnt - t0, 0);
    chk("zl_busy_cnt", busy_cnt - b0, 0);
    chk("zl_done_cnt", done_cnt - d0, 1);

    // 4. tap lockout during STREAM
    base = rq.size();
    start(NS);
    send(vec[0].s, 0, 1'b0);
    send(vec[1].s, 0, 1'b0);
    bus.i_tap_valid = 1'b1; bus.i_tap_idx = 4'd3; bus.i_tap_data = 12'd99;
    @(negedge clk);
    chk("lock_tap_ready", bus.o_tap_ready, 1'b0);
    @(posedge clk); #1;
    bus.i_tap_valid = 1'b0;
    chk("lock_tap3", bus.o_fir_taps[3*IW +: IW], 12'd11);
    for (int i = 2; i < NS; i++) send(vec[i].s, 0, 1'b0);
    wait_done("lock_done");
    check_res("lock", base);
    chk("lock_taps_after", bus.o_fir_taps, exp_taps);

    // 5. input gaps: valid toggles 1,0,1,0...
    impulse_burst("gap", 1'b1);

    // 6. reset in the middle of STREAM
    d0 = done_cnt;
    start(NS);
    for (int i = 0; i < 4; i++) send(vec[i].s, 0, 1'b0);
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = 12'd5;
    rst = 1'b1;
    #1;
    chk("mrst_busy", bus.o_busy, 1'b0);
    chk("mrst_done", bus.o_done, 1'b0);
    chk("mrst_tap_ready", bus.o_tap_ready, 1'b0);
    chk("mrst_s_ready", bus.o_s_ready, 1'b0);
    chk("mrst_ce", bus.o_fir_ce, 1'b0);
    chk("mrst_sample", bus.o_fir_sample, '0);
    chk("mrst_tap_wr", bus.o_fir_tap_wr, 1'b0);
    chk("mrst_taps", bus.o_fir_taps, '0);
    chk("mrst_out_len", bus.o_fir_out_len, '0);
    chk("mrst_r_valid", bus.o_r_valid, 1'b0);
    chk("mrst_r_data", bus.o_r_data, '0);
    chk("mrst_r_last", bus.o_r_last, 1'b0);
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("mrst_no_done", done_cnt - d0, 0);
    chk("mrst_tap_ready_back", bus.o_tap_ready, 1'b1);
    write_taps();
    impulse_burst("post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
